// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one external RAM port between the instruction-fetch and
//             data-cache requesters. A granted request is registered onto the
//             ram_* outputs and held until ram_ack_i or a wait timeout. A
//             one-cycle ack, with read data, then goes back to the winner.
//             When both ports are pending, the grant alternates round-robin.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             inst_*            - instruction read port (req/addr in, data/ack out)
//             data_*            - data port (req/we/sel/addr/wdata in, rdata/ack out)
//             ram_*             - external RAM handshake (ce/we/sel/addr/data out,
//                                 data/ack in)
//             err_o             - pulses with the ack of a timed-out transaction
//             stallreq_o        - high while either request is still unanswered
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_ack_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ack_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ack_i,
    output logic        err_o,
    output logic        stallreq_o
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INST_BUSY = 2'd1,
        ST_DATA_BUSY = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;   // 0 = inst, 1 = data; also the port being served
    logic [7:0]  cnt_q,        cnt_d;
    logic        ram_ce_q,     ram_ce_d;
    logic        ram_we_q,     ram_we_d;
    logic [3:0]  ram_sel_q,    ram_sel_d;
    logic [31:0] ram_addr_q,   ram_addr_d;
    logic [31:0] ram_data_q,   ram_data_d;
    logic [31:0] resp_q,       resp_d;
    logic        err_q,        err_d;

    logic w_grant_inst;
    logic w_grant_data;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ram_ce_d     = ram_ce_q;
        ram_we_d     = ram_we_q;
        ram_sel_d    = ram_sel_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        resp_d       = resp_q;
        err_d        = err_q;
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_req_i && data_req_i) begin
                    // Favour whichever port was not served last.
                    w_grant_inst = last_grant_q;
                    w_grant_data = ~last_grant_q;
                end else begin
                    w_grant_inst = inst_req_i;
                    w_grant_data = data_req_i;
                end
            end

            ST_INST_BUSY, ST_DATA_BUSY: begin
                if (ram_ack_i) begin
                    // Ack wins over a coincident timeout.
                    resp_d    = ram_we_q ? 32'd0 : ram_data_i;
                    ram_ce_d  = 1'b0;
                    ram_we_d  = 1'b0;
                    ram_sel_d = 4'd0;
                    state_d   = ST_RESP;
                end else if (cnt_q == c_timeout) begin
                    ram_ce_d   = 1'b0;
                    ram_we_d   = 1'b0;
                    ram_sel_d  = 4'd0;
                    ram_addr_d = 32'd0;
                    ram_data_d = 32'd0;
                    resp_d     = 32'd0;
                    err_d      = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin // ST_RESP
                // The served port's request is still high here and is ignored.
                resp_d  = 32'd0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
                if (last_grant_q) begin
                    w_grant_inst = inst_req_i;
                end else begin
                    w_grant_data = data_req_i;
                end
            end
        endcase

        if (w_grant_inst) begin
            ram_ce_d     = 1'b1;
            ram_we_d     = 1'b0;
            ram_sel_d    = 4'b1111;
            ram_addr_d   = inst_addr_i;
            ram_data_d   = 32'd0;
            last_grant_d = 1'b0;
            cnt_d        = 8'd0;
            state_d      = ST_INST_BUSY;
        end else if (w_grant_data) begin
            ram_ce_d     = 1'b1;
            ram_we_d     = data_we_i;
            ram_sel_d    = data_sel_i;
            ram_addr_d   = data_addr_i;
            ram_data_d   = data_wdata_i;
            last_grant_d = 1'b1;
            cnt_d        = 8'd0;
            state_d      = ST_DATA_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b0;
            cnt_q        <= 8'd0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_sel_q    <= 4'd0;
            ram_addr_q   <= 32'd0;
            ram_data_q   <= 32'd0;
            resp_q       <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_sel_q    <= ram_sel_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
        end
    end

    logic w_resp;
    assign w_resp       = (state_q == ST_RESP);
    assign inst_ack_o   = w_resp & ~last_grant_q;
    assign data_ack_o   = w_resp &  last_grant_q;
    assign inst_data_o  = inst_ack_o ? resp_q : 32'd0;
    assign data_rdata_o = data_ack_o ? resp_q : 32'd0;
    assign err_o        = w_resp & err_q;

    assign ram_ce_o   = ram_ce_q;
    assign ram_we_o   = ram_we_q;
    assign ram_sel_o  = ram_sel_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_data_o = ram_data_q;

    assign stallreq_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external RAM port between the instruction-fetch requester and the data-cache requester. Each request is registered at grant and sequenced through a handshake with the RAM's acknowledge. A one-cycle acknowledge, with read data, goes back to the winning requester. The block sits between the IF stage / data cache and RAM, and raises a stall request to ctrl while any request is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: RAM wait cycles before a transaction is aborted (1..255, 8-bit counter).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- inst_req_i  in  1  instruction read request; held with address until inst_ack_o.
- inst_addr_i  in  32  instruction word address.
- inst_data_o  out  32  fetched word; valid while inst_ack_o = 1.
- inst_ack_o  out  1  one-cycle completion pulse.
- data_req_i  in  1  data request; all data_* inputs held until data_ack_o.
- data_we_i  in  1  1 = write, 0 = read.
- data_sel_i  in  4  byte enables.
- data_addr_i  in  32  data address.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data; valid while data_ack_o = 1; 0 for writes.
- data_ack_o  out  1  one-cycle completion pulse.
- ram_ce_o, ram_we_o  out  1 each  RAM chip enable and write enable.
- ram_sel_o  out  4  RAM byte enables.
- ram_addr_o, ram_data_o  out  32 each  RAM address and write data.
- ram_data_i  in  32  RAM read data; valid when ram_ack_i = 1.
- ram_ack_i  in  1  RAM completion; may come 0..N cycles after ram_ce_o rises.
- err_o  out  1  one-cycle pulse, coincident with the ack of a timed-out transaction.
- stallreq_o  out  1  to ctrl: (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o), combinational.

## Operation
- States: IDLE, INST_BUSY, DATA_BUSY, RESP.
- Register last_grant (0 = inst, 1 = data) holds the previous grant.
- In IDLE:
  - One request pending: grant it.
  - Both pending: grant the one not equal to last_grant (round-robin).
  - None pending: stay in IDLE.
- Grant actions:
  - Register the request fields into the ram_* outputs and set ram_ce_o = 1.
  - Set ram_we_o = data_we_i for data; 0 for inst.
  - Set ram_sel_o = data_sel_i for data; 4'b1111 for inst.
  - Update last_grant; clear the wait counter; enter INST_BUSY or DATA_BUSY.
- In *_BUSY:
  - ram_* outputs stay constant.
  - ram_ack_i = 1: capture ram_data_i into the response register (0 for writes), drop ram_ce_o / ram_we_o / ram_sel_o to 0, enter RESP.
  - Otherwise increment the wait counter. When it reaches TIMEOUT_CYCLES, drop the ram_* outputs, load response 0, set the error flag, enter RESP.
- In RESP:
  - Pulse the served port's ack_o with the response data, plus err_o if flagged.
  - The served requester's req_i is still high this cycle and is ignored.
  - If the other requester is pending, grant it directly (RESP → its BUSY). Else → IDLE.
- The inst port never writes. inst_data_o and data_rdata_o are 0 whenever their ack is low.

## Timing
- Reset (synchronous): state IDLE, last_grant = 0. All outputs 0: ram_*, *_ack_o, *_data_o, err_o. stallreq_o follows the req inputs.
- Reset mid-transaction: the next edge forces IDLE and ram_ce_o = 0; no ack is issued and the transaction is dropped.
- Zero-wait RAM: req sampled at edge T → ram_ce_o high T+1 → ack_o high T+2 → ram_ce_o low T+2.
- Each RAM wait cycle adds 1 cycle of latency.
- A back-to-back other-port grant in RESP puts ram_ce_o high in the cycle after the ack (no IDLE bubble).
- The same port re-requesting needs IDLE first, so its minimum spacing is 3 cycles between acks.
- Timeout: ack plus err_o is issued TIMEOUT_CYCLES+1 cycles after ram_ce_o rises.
- A ram_ack_i arriving in IDLE or RESP is ignored.
- When ram_ack_i and the timeout condition coincide, ram_ack_i wins: no error.

## Test plan
- Reset, then inst read 0x0000_0100 alone; RAM acks after 0 waits with 0x2402_0005 → inst_ack_o and inst_data_o = 0x2402_0005 exactly 2 cycles after req; stallreq_o high for cycles 0–1, low in the ack cycle.
- Data write 0x0000_0200, sel 4'b0011, wdata 0xDEAD_BEEF, RAM waits 3 cycles → ram_we_o = 1, ram_sel_o = 0011 held for 4 cycles; data_ack_o at cycle 5; data_rdata_o = 0.
- Both requests asserted in the same cycle after reset → data granted first (last_grant = 0); inst ram_ce_o rises the cycle after data_ack_o with no IDLE gap; inst acked 2 cycles later.
- Both requesters re-request continuously for 8 transactions → grants strictly alternate; neither port is starved.
- TIMEOUT_CYCLES = 4, RAM never acks a data read → ram_ce_o drops and data_ack_o + err_o pulse with data_rdata_o = 0, 5 cycles after ram_ce_o rose; next request is served normally.
- rst asserted in DATA_BUSY at wait cycle 2 → next edge ram_ce_o = 0, no data_ack_o; after rst drops, the still-held request is re-granted from IDLE.
